// File: rtl/data_mem_ctrl.sv
// Data memory controller: IDLE/BUSY/DONE FSM stalling the core
// for 1+LATENCY cycles per aligned word load/store.
//
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous active-high reset
//   mem_read  - load request
//   mem_write - store request
//   addr      - byte address (word aligned; high bits wrap)
//   wdata     - store data
//   rdata     - registered load data, valid from the DONE cycle
//   stall     - hold PC/pipeline while high
//   done      - one-cycle completion pulse
//   err       - illegal request (both ops or misaligned) in IDLE
module data_mem_ctrl #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          r_wr;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH];

  logic w_any;
  logic w_bad;
  logic w_req;
  logic w_fire;
  logic w_unused;

  assign w_any  = mem_read | mem_write;
  assign w_bad  = (mem_read & mem_write) | (addr[1:0] != 2'b00);
  assign w_req  = w_any & ~w_bad;
  assign w_fire = (r_state == S_BUSY) && (r_cnt == 4'd0);

  // Address bits above the word index are deliberately ignored.
  assign w_unused = ^addr[31:AW+2];

  assign rdata = r_rdata;

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        err = w_any & w_bad;
        if (w_req) begin
          stall  = 1'b1;
          w_next = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (r_cnt == 4'd0) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_req) begin
        r_wr    <= mem_write;
        r_idx   <= addr[AW+1:2];
        r_wdata <= wdata;
        r_cnt   <= 4'(LATENCY - 1);
      end
      if (r_state == S_BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_fire && !r_wr) begin
        r_rdata <= r_mem[r_idx];
      end
    end
  end

  // No reset on the array: contents survive reset, but a write
  // in flight when reset arrives is dropped.
  always_ff @(posedge clk) begin
    if (!reset && w_fire && r_wr) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised scoreboard bench for data_mem_ctrl against an
// array-based memory model.
module tb_data_mem_ctrl;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;
  localparam int TMO     = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        err;

  logic [31:0] exp_q [$];
  logic [31:0] model [DEPTH];
  logic [31:0] last_rd = 32'd0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          stall_run = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout after %0d cycles", name, TMO);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $fatal(1, "timeout");
  endtask

  // Monitor: every done pulse pops one expected rdata and checks
  // the number of stalled cycles leading up to it.
  always @(negedge clk) begin
    if (reset) begin
      stall_run = 0;
    end else if (done) begin
      check("stall_cycles", 32'(stall_run), 32'(1 + LATENCY));
      stall_run = 0;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL done_unexpected: got done=1 expected none");
      end else begin
        check("rdata_at_done", rdata, exp_q.pop_front());
      end
    end else if (stall) begin
      stall_run++;
    end
  end

  function automatic int widx(input logic [31:0] a);
    return int'(a >> 2) % DEPTH;
  endfunction

  // Called either at posedge+1 in IDLE or at the DONE negedge.
  task automatic access(input bit rd,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [31:0] busy_a);
    int k;
    mem_read  = rd;
    mem_write = !rd;
    addr      = a;
    wdata     = d;
    if (rd) last_rd = model[widx(a)];
    else model[widx(a)] = d;
    exp_q.push_back(last_rd);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!stall && k < TMO);
    if (!stall) timeout("accept");
    @(posedge clk);
    #1;
    mem_read  = 1'($urandom);
    mem_write = 1'($urandom);
    addr      = busy_a;
    wdata     = $urandom;
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = $urandom;
    wdata     = $urandom;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < TMO);
    if (!done) timeout("done");
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1.
  task automatic err_case(input bit rd, input bit wr,
                          input logic [31:0] a);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    @(negedge clk);
    check("err_flag", 32'(err), 32'd1);
    check("err_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("err_no_busy", 32'(stall | done), 32'd0);
    check("err_rdata", rdata, last_rd);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid(input logic [31:0] a,
                           input logic [31:0] d);
    int k;
    mem_read  = 1'b0;
    mem_write = 1'b1;
    addr      = a;
    wdata     = d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!stall && k < TMO);
    if (!stall) timeout("rst_accept");
    @(posedge clk);
    #1;
    reset     = 1'b1;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_rd = 32'd0;
    @(negedge clk);
    check("rst_mid_rdata", rdata, 32'd0);
    check("rst_mid_idle", 32'({stall, done, err}), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = 32'd0;
    wdata     = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_outs", 32'({stall, done, err}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_outs", 32'({stall, done, err}), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < DEPTH; i++) begin
      access(1'b0, 32'(i * 4), $urandom, $urandom);
    end
    idle();

    access(1'b0, 32'h10, 32'hDEADBEEF, $urandom);
    idle();
    access(1'b1, 32'h10, 32'd0, $urandom);
    idle();
    @(negedge clk);
    check("lw_0x10", rdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    err_case(1'b1, 1'b0, 32'h13);
    err_case(1'b1, 1'b1, 32'h10);
    access(1'b1, 32'h10, 32'd0, $urandom);
    idle();
    @(negedge clk);
    check("both_high_intact", rdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    access(1'b0, 32'h400, 32'h12345678, $urandom);
    idle();
    access(1'b1, 32'h0, 32'd0, $urandom);
    idle();
    @(negedge clk);
    check("wrap_lw_0", rdata, 32'h12345678);
    @(posedge clk);
    #1;

    reset_mid(32'h20, 32'hA5A5A5A5);
    access(1'b1, 32'h20, 32'd0, $urandom);
    idle();

    access(1'b1, 32'h10, 32'd0, 32'h20);
    access(1'b1, 32'h20, 32'd0, 32'h10);
    idle();

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = $urandom & 32'hFFFF_FFFC;
      access(1'($urandom), a, $urandom, $urandom);
      if ($urandom_range(2, 0) == 0) begin
        idle();
        if ($urandom_range(3, 0) == 0) begin
          err_case(1'b1, 1'($urandom), a | 32'($urandom_range(3, 1)));
        end
      end
    end
    idle();
    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words in the data memory (power of two).
REQ-002 Parameter LATENCY, default 2: number of BUSY wait cycles per access (legal range 1..15).
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port mem_read, input, 1: load request from the core control path.
REQ-006 Port mem_write, input, 1: store request from the core control path.
REQ-007 Port addr, input, 32: byte address from the ALU.
REQ-008 Port wdata, input, 32: store data.
REQ-009 Port rdata, output, 32: load data, registered.
REQ-010 Port stall, output, 1: the core holds its PC and pipeline while this is high.
REQ-011 Port done, output, 1: one-cycle pulse when an access completes.
REQ-012 Port err, output, 1: illegal request indication; no access is performed.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 A request exists when exactly one of mem_read or mem_write is high, and addr[1:0] = 00.
REQ-015 err SHALL equal (state = IDLE) AND (mem_read OR mem_write) AND (both high OR addr[1:0] != 00), combinationally; stall stays 0 and the state stays IDLE.
REQ-016 In IDLE with a legal request, the block SHALL assert stall combinationally in the same cycle.
REQ-017 On that edge it SHALL latch the opcode (read/write), word index = addr[log2(DEPTH)+1:2], and wdata.
REQ-018 On that same edge it SHALL load the wait counter with LATENCY-1 and move to BUSY.
REQ-019 The block SHALL ignore addr bits above log2(DEPTH)+1; addresses wrap modulo DEPTH words.
REQ-020 In BUSY, stall SHALL be 1 and the counter SHALL decrement each cycle.
REQ-021 When the counter is 0 in BUSY, the next edge SHALL perform the access and move to DONE: a write stores the latched wdata to the memory; a read loads memory[index] into rdata.
REQ-022 In DONE, stall SHALL be 0 and done SHALL be 1 for exactly one cycle; the next edge returns to IDLE unconditionally.
REQ-023 Request inputs SHALL be ignored in BUSY and DONE; changes to addr and wdata after latching SHALL have no effect.
REQ-024 Total stall cycles per legal access SHALL be 1+LATENCY; rdata SHALL be valid from the DONE cycle.
REQ-025 rdata SHALL hold its value until the next completed read; writes SHALL NOT modify rdata.
REQ-026 A new request present during DONE SHALL be sampled only after the return to IDLE (back-to-back accesses are separated by the DONE cycle).

Reset
REQ-027 On reset, state SHALL be IDLE, the counter 0, rdata 0, and done 0; stall and err follow their combinational definitions from IDLE.
REQ-028 Reset in BUSY SHALL abort the access: a pending write SHALL NOT be committed, and rdata SHALL be 0.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-031 Write then read, LATENCY=2: sw addr=0x10, wdata=0xDEADBEEF -> stall high 3 cycles, done pulse. Then lw addr=0x10 -> rdata=0xDEADBEEF in the DONE cycle.
REQ-032 Misaligned access: mem_read=1, addr=0x13 -> err=1 and stall=0 in the same cycle; no state change; rdata unchanged.
REQ-033 Illegal combination: mem_read=1 and mem_write=1 -> err=1, no access; the prior contents of the addressed word are intact.
REQ-034 Wrap-around, DEPTH=256: sw addr=0x400, data 0x12345678, then lw addr=0x0 -> rdata=0x12345678.
REQ-035 Reset mid-operation: sw addr=0x20, data 0xA5A5A5A5, reset in the first BUSY cycle; then lw addr=0x20 -> rdata returns the old value, not 0xA5A5A5A5.
REQ-036 Input change while busy: lw addr=0x10 with addr changed to 0x20 during BUSY -> the read returns memory[0x10]; the next lw is serviced only after the DONE cycle.
